// File: rtl/ex_pkg.sv
// ============================================================================
// Package : ex_pkg  -- shared encodings for the execute stage
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_REG  = 2'd0;
  localparam logic [1:0] FWD_WB   = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;
  localparam logic [1:0] FWD_ZERO = 2'd3;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_JUMP = 3'd5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  // Which operands of an M op are treated as two's complement.
  function automatic logic md_a_signed(input logic [2:0] op);
    return op[2] ? ~op[0] : (op[1:0] != 2'b11);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return op[2] ? ~op[0] : ~op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module : alu  -- XLEN-wide integer ALU
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_op,
  output logic [XLEN-1:0] o_y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SLT:  o_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SRL:  o_y = i_a >> w_shamt;
      ALU_SRA:  o_y = XLEN'($signed(i_a) >>> w_shamt);
      ALU_OR:   o_y = i_a | i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_PASS: o_y = i_b;
      default:  o_y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/brc.sv
// ============================================================================
// Module : brc  -- branch condition evaluator
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module brc
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_unsigned,
  input  logic [2:0]      i_br_type,
  output logic            o_taken
);

  logic w_eq;
  logic w_lt;

  assign w_eq = (i_a == i_b);
  assign w_lt = i_unsigned ? (i_a < i_b) : ($signed(i_a) < $signed(i_b));

  always_comb begin
    o_taken = 1'b0;
    case (i_br_type)
      BR_NONE: o_taken = 1'b0;
      BR_EQ:   o_taken = w_eq;
      BR_NE:   o_taken = ~w_eq;
      BR_LT:   o_taken = w_lt;
      BR_GE:   o_taken = ~w_lt;
      BR_JUMP: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ============================================================================
// Module : ex_muldiv  -- iterative RV32M/RV64M unit (built only with EX_MULDIV_EN)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef EX_MULDIV_EN
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] c_most_neg = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         r_state;
  md_op_e            r_op;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;

  // Acceptance: magnitudes, signs and the two results that skip iteration.
  logic            w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_special;

  assign w_a_neg   = md_a_signed(i_op) & i_a[XLEN-1];
  assign w_b_neg   = md_b_signed(i_op) & i_b[XLEN-1];
  assign w_a_mag   = w_a_neg ? -i_a : i_a;
  assign w_b_mag   = w_b_neg ? -i_b : i_b;
  assign w_div0    = i_op[2] & (i_b == '0);
  assign w_ovf     = i_op[2] & ~i_op[0] & (i_a == c_most_neg) & (i_b == '1);
  assign w_special = i_op[1] ? (w_div0 ? i_a : '0) : (w_div0 ? '1 : i_a);

  // One shift-add step: r_acc = {partial product, remaining multiplier bits}.
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

  // One restoring step: r_acc = {remainder, dividend bits becoming quotient}.
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [2*XLEN-1:0] w_div_next;
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh[XLEN-1:0] - r_b;
  assign w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

  logic [2*XLEN-1:0] w_acc_next, w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_final;
  assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;
  assign w_prod     = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quot     = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem      = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_final = w_rem;
    case (r_op)
      MD_MUL:                       w_final = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_final = w_quot;
      default:                      w_final = w_rem;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= MD_IDLE;
      r_op     <= MD_MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (i_flush) begin
      r_state <= MD_IDLE;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_valid) begin
            r_op    <= md_op_e'(i_op);
            r_cnt   <= '0;
            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
            r_b     <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_div0 || w_ovf) begin
              r_result <= w_special;
              r_state  <= MD_DONE;
            end else begin
              r_state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN - 1)) begin
            r_result <= w_final;
            r_state  <= MD_DONE;
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign o_stall  = i_rst_n & ~i_flush &
                    ((i_valid & (r_state == MD_IDLE)) | (r_state == MD_BUSY));
  assign o_done   = (r_state == MD_DONE);
  assign o_result = r_result;

endmodule
`endif

`default_nettype wire

// File: rtl/ex_stage_md.sv
// ============================================================================
// Module : ex_stage_md  -- execute stage: forwarding, ALU, branch, M-unit
//          The M-unit is included only when EX_MULDIV_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_pc_cur,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imme_value,
  input  logic [XLEN-1:0] i_wb_forwarding,
  input  logic [XLEN-1:0] i_mem_forwarding,
  input  logic [1:0]      i_forward_A,
  input  logic [1:0]      i_forward_B,
  input  logic            i_rs1_sel,
  input  logic            i_imme_sel,
  input  logic [3:0]      i_alu_op,
  input  logic            i_md_valid,
  input  logic [2:0]      i_md_op,
  input  logic            i_flush,
  input  logic            i_jalr_iden,
  input  logic            i_br_unsigned,
  input  logic [2:0]      i_br_type,
  output logic            o_stall,
  output logic            o_brc_pc_sel,
  output logic [XLEN-1:0] o_pc_br,
  output logic [XLEN-1:0] o_alu_data,
  output logic [XLEN-1:0] o_operand_b
);

  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_alu_a, w_alu_b, w_alu_y;

  always_comb begin
    w_fwd_a = '0;
    case (i_forward_A)
      FWD_REG:  w_fwd_a = i_rs1_data;
      FWD_WB:   w_fwd_a = i_wb_forwarding;
      FWD_MEM:  w_fwd_a = i_mem_forwarding;
      FWD_ZERO: w_fwd_a = '0;
      default:  w_fwd_a = '0;
    endcase
  end

  always_comb begin
    w_fwd_b = '0;
    case (i_forward_B)
      FWD_REG:  w_fwd_b = i_rs2_data;
      FWD_WB:   w_fwd_b = i_wb_forwarding;
      FWD_MEM:  w_fwd_b = i_mem_forwarding;
      FWD_ZERO: w_fwd_b = '0;
      default:  w_fwd_b = '0;
    endcase
  end

  assign w_alu_a     = i_rs1_sel ? i_pc_cur : w_fwd_a;
  assign w_alu_b     = i_imme_sel ? i_imme_value : w_fwd_b;
  assign o_operand_b = w_fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .i_a  (w_alu_a),
    .i_b  (w_alu_b),
    .i_op (i_alu_op),
    .o_y  (w_alu_y)
  );

  // The comparator sees register operands even when the ALU takes the immediate.
  brc #(.XLEN(XLEN)) u_brc (
    .i_a        (w_fwd_a),
    .i_b        (w_fwd_b),
    .i_unsigned (i_br_unsigned),
    .i_br_type  (i_br_type),
    .o_taken    (o_brc_pc_sel)
  );

  assign o_pc_br = i_jalr_iden ? w_alu_y : (i_pc_cur + i_imme_value);

`ifdef EX_MULDIV_EN
  logic            w_md_done;
  logic [XLEN-1:0] w_md_result;

  ex_muldiv #(.XLEN(XLEN)) u_muldiv (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_md_valid),
    .i_flush  (i_flush),
    .i_op     (i_md_op),
    .i_a      (w_fwd_a),
    .i_b      (w_fwd_b),
    .o_stall  (o_stall),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  assign o_alu_data = w_md_done ? w_md_result : w_alu_y;
`else
  logic w_unused;
  assign w_unused   = ^{i_clk, i_rst_n, i_md_valid, i_md_op, i_flush};
  assign o_stall    = 1'b0;
  assign o_alu_data = w_alu_y;
`endif

endmodule

`default_nettype wire

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the in-order RISC-V pipeline: operand forwarding muxes, ALU, branch comparator and branch/JALR target, plus an iterative RV32M/RV64M multiply/divide unit. Sits between the ID/EX and EX/MEM pipeline registers. While a multiply/divide is in flight it raises a stall to the hazard unit.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low
- i_pc_cur  in  XLEN  PC of the instruction in EX
- i_rs1_data, i_rs2_data  in  XLEN  register file operands
- i_imme_value  in  XLEN  sign-extended immediate
- i_wb_forwarding, i_mem_forwarding  in  XLEN  forwarded results
- i_forward_A, i_forward_B  in  2  0 = reg/PC, 1 = WB, 2 = MEM, 3 = zero
- i_rs1_sel  in  1  operand A select: 1 = PC, 0 = rs1
- i_imme_sel  in  1  ALU operand B select: 1 = immediate, 0 = forwarded rs2
- i_alu_op  in  4  ALU operation
- i_md_valid  in  1  EX holds an M-extension instruction
- i_md_op  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- i_flush  in  1  kill the EX instruction
- i_jalr_iden, i_br_unsigned  in  1  JALR select; unsigned compare
- i_br_type  in  3  branch condition
- o_stall  out  1  hold IF/ID/EX and insert a bubble into MEM
- o_brc_pc_sel  out  1  branch/jump taken
- o_pc_br  out  XLEN  JALR ? ALU result : PC + immediate
- o_alu_data  out  XLEN  ALU result, or M result in DONE
- o_operand_b  out  XLEN  forwarded rs2 (store data)

## Operation
- Forwarding, ALU, branch comparison and the o_pc_br selection are combinational.
- The comparator always uses the forwarded operands, never the immediate.
- M-unit FSM states: IDLE, BUSY, DONE.
- **IDLE**, with i_md_valid=1 and i_flush=0:
  - Latch the forwarded A/B operands and i_md_op.
  - Go to BUSY, or straight to DONE for a special case.
  - Later changes on the forwarding inputs must not affect the result.
- **BUSY**:
  - Multiply: shift-add over magnitudes, one bit per cycle, for XLEN cycles into a 2·XLEN product. Sign is fixed up at the end per MULH/MULHSU/MULHU/MUL.
  - Divide: restoring, one quotient bit per cycle, XLEN cycles, on magnitudes. Quotient takes the sign of a^b; remainder takes the sign of the dividend.
- **DONE**: o_alu_data = latched result. Then unconditionally return to IDLE.
- Special cases (resolved at acceptance, go directly to DONE):
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend; remainder 0.
- o_stall = i_md_valid & (state==IDLE) | (state==BUSY), gated by !i_flush.
- i_flush in any state forces IDLE next cycle and drops o_stall the same cycle.
- Reset (i_rst_n=0 at a clock edge) has the same effect as i_flush. Reset values:
  - state IDLE
  - counter 0
  - result 0
  - o_stall 0
- Back-to-back M instructions: DONE advances the pipeline; the next instruction is accepted in the following IDLE cycle.
- Branch outputs are unaffected by M state; branches are never M-type.

## Timing
- Non-M instructions: zero-cycle combinational path, no stall.
- Iterative M op occupies EX for XLEN+2 cycles (34 cycles at XLEN=32):
  - 1 acceptance cycle plus XLEN BUSY cycles, all with o_stall=1;
  - then DONE with o_stall=0 and the result valid.
- Special-case M op: 2 cycles, namely acceptance (stalled) then DONE.
- Counter width: $clog2(XLEN)+1; it wraps only through reset to 0 on acceptance.

## Configuration
- Macro: EX_MULDIV_EN.
- Defined: M-unit, FSM and o_stall logic as above.
- Undefined:
  - No M logic is compiled; i_md_valid and i_md_op are ignored.
  - o_stall is tied to 0.
  - o_alu_data is always the ALU result.
  - i_clk and i_rst_n are unused.

## Structure
- Package ex_pkg:
  - md_op_e (funct3 encodings)
  - md_state_e (IDLE/BUSY/DONE)
  - forwarding select constants FWD_REG/FWD_WB/FWD_MEM/FWD_ZERO
  - branch type encodings
- Sub-module ex_muldiv, parametrised by XLEN. It holds the FSM, operand latches, iteration counter and result register, and exports stall and result.
- The existing alu and brc are reused with an XLEN parameter.

## Test plan
- **MUL:** 7 × 0xFFFFFFFD → o_stall high for 33 cycles; result 0xFFFFFFEB in cycle 34; MEM sees bubbles only.
- **MULHU:** 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Special cases:** DIVU 100/0 → 0xFFFFFFFF and REMU → 100; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0. Each takes 2 cycles.
- **Operand latch:** DIV with i_forward_A=2, i_mem_forwarding=50, rs2=5. Drive i_mem_forwarding=0 from cycle 2 → result 10.
- **Kill mid-operation:** i_flush at BUSY cycle 10 → o_stall 0 the same cycle, IDLE next cycle. Repeat with i_rst_n low → IDLE, result 0.
- **Back-to-back:** REM −7/2 then BEQ x, x → REM yields 0xFFFFFFFF. After the stall drops, o_brc_pc_sel=1 and o_pc_br = PC + immediate.
